// File: rtl/board_renderer.sv
// Walks the 64 board squares, fetches each piece through the arbiter view port and
// plots the square as an SQ_SIZE x SQ_SIZE pixel block with checker, piece and cursor.
module board_renderer #(
  parameter int SQ_SIZE  = 8,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] cursor_addr,
  input  logic       cursor_en,
  input  logic       mem_grant,
  input  logic [3:0] data_in,
  output logic       mem_req,
  output logic [5:0] address_view,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(SQ_SIZE);
  localparam logic [CW-1:0] PMAX = CW'(SQ_SIZE - 1);
  localparam logic [CW-1:0] INLO = CW'(SQ_SIZE / 4);
  localparam logic [CW-1:0] INHI = CW'(3 * SQ_SIZE / 4);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD1, S_RD2, S_DRAW, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    sq_q, sq_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic [3:0]    piece_q, piece_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      sq_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      piece_q <= '0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      px_q    <= px_d;
      py_q    <= py_d;
      piece_q <= piece_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    px_d    = px_q;
    py_d    = py_q;
    piece_d = piece_q;
    mem_req = 1'b0;
    plot    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_REQ;
        sq_d    = '0;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_grant) state_d = S_RD1;
      end
      // Any gap in the grant invalidates the in-flight read; refetch from REQ.
      S_RD1: begin
        mem_req = 1'b1;
        state_d = mem_grant ? S_RD2 : S_REQ;
      end
      S_RD2: begin
        mem_req = 1'b1;
        if (mem_grant) begin
          piece_d = data_in;
          state_d = S_DRAW;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DRAW: begin
        plot = 1'b1;
        if (px_q == PMAX) begin
          px_d = '0;
          if (py_q == PMAX) begin
            py_d = '0;
            if (sq_q == 6'd63) begin
              state_d = S_DONE;
            end else begin
              sq_d    = sq_q + 6'd1;
              state_d = S_REQ;
            end
          end else begin
            py_d = py_q + 1'b1;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        sq_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign address_view = sq_q;

  logic [2:0] col, row;
  logic       border, inner, cursor_hit;
  assign col        = sq_q[2:0];
  assign row        = sq_q[5:3];
  assign border     = (px_q == '0) || (px_q == PMAX) || (py_q == '0) || (py_q == PMAX);
  assign inner      = (px_q >= INLO) && (px_q < INHI) && (py_q >= INLO) && (py_q < INHI);
  assign cursor_hit = cursor_en && (cursor_addr == sq_q);

  // SQ_SIZE is a power of two, so col*SQ_SIZE+px is just {col, px}.
  always_comb begin
    x      = '0;
    y      = '0;
    colour = '0;
    if (state_q == S_DRAW) begin
      x = 8'(X_OFFSET) + 8'({col, px_q});
      y = 7'(Y_OFFSET) + 7'({row, py_q});
      if (border && cursor_hit)
        colour = 3'b100;
      else if (inner && piece_q[2:0] != 3'd0)
        colour = (piece_q[2:0] == 3'd7) ? 3'b101 : (piece_q[3] ? 3'b001 : 3'b111);
      else
        colour = (row[0] ^ col[0]) ? 3'b010 : 3'b110;
    end
  end

endmodule
